// File: rtl/cl_sde_stream_proc.sv
`timescale 1ns/1ps
// Purpose: split 512-bit beats into keep-qualified DW lanes, FIFO them, XOR-reduce every D lanes into a keyed result.
// Latency: beat accepted at t, lane 0 pushed at t+1, popped at t+2, ots_valid high after t+2.
// Backpressure: full FIFO stalls the holding register; ots_ready=0 or en=0 stops pops; no lane is ever dropped.
// Ports: clk/rst_n; cfg_srm_* register access (ack + rdata one cycle after strobe);
//        ins_* AXI-S input (ins_user ignored); ots_* AXI-S output (one result per beat).

module cl_sde_sp_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module cl_sde_stream_proc #(
  parameter int DW         = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int RES_W      = 160
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [11:0]  cfg_srm_addr,
  input  logic         cfg_srm_wr,
  input  logic         cfg_srm_rd,
  input  logic [31:0]  cfg_srm_wdata,
  output logic         srm_cfg_ack,
  output logic [31:0]  srm_cfg_rdata,
  input  logic         ins_valid,
  output logic         ins_ready,
  input  logic [511:0] ins_data,
  input  logic [63:0]  ins_keep,
  input  logic [63:0]  ins_user,
  input  logic         ins_last,
  output logic         ots_valid,
  input  logic         ots_ready,
  output logic [511:0] ots_data,
  output logic [63:0]  ots_keep,
  output logic [63:0]  ots_user,
  output logic         ots_last
);
  localparam int NL  = 512 / DW;
  localparam int KB  = DW / 8;
  localparam int NK  = DW / 32;
  localparam int LVW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [63:0] KEEP_MASK = (RES_W >= 512) ? {64{1'b1}} : ((64'd1 << (RES_W / 8)) - 64'd1);

  // registers
  logic        ctrl_en;
  logic [4:0]  decim;
  logic [31:0] key;
  logic [31:0] cnt_beats;
  logic [31:0] cnt_drop;
  logic [31:0] cnt_res;
  logic        clr;
  logic [31:0] rd_val;

  // holding register: pend holds the valid lanes not yet pushed
  logic [511:0]   hold_data;
  logic [NL-1:0]  pend;
  logic [NL-1:0]  pend_rest;
  logic [NL-1:0]  lane_oh;
  logic           hold_last;
  logic           busy;
  logic           rdy_en;
  logic [NL-1:0]  vmask;
  logic [31:0]    drop_n;
  logic [DW-1:0]  lane_dat;
  logic           final_lane;
  logic           accept;
  logic           push;

  // fifo
  logic [DW+1:0]  push_dat;
  logic [DW+1:0]  fifo_rdat;
  logic           fifo_full;
  logic           fifo_empty;
  logic [LVW-1:0] fifo_level;

  // reducer
  logic           pop;
  logic           e_last;
  logic           e_empty;
  logic [DW-1:0]  e_dat;
  logic [DW-1:0]  acc;
  logic [DW-1:0]  acc_x;
  logic [DW-1:0]  mix;
  logic [4:0]     cnt;
  logic [4:0]     cnt_x;
  logic [4:0]     d_eff;
  logic           close;
  logic [511:0]   res_nxt;
  logic           unused_ok;

  assign unused_ok = ^ins_user;

  always_comb begin
    vmask  = '0;
    drop_n = '0;
    for (int i = 0; i < NL; i++) begin
      vmask[i] = &ins_keep[i*KB +: KB];
      if (!(&ins_keep[i*KB +: KB])) drop_n = drop_n + 32'd1;
    end
  end

  // lowest pending lane goes first; invalid lanes were never in pend, so they cost nothing
  assign lane_oh    = pend & (~pend + NL'(1));
  assign pend_rest  = pend & (pend - NL'(1));
  assign final_lane = (pend_rest == '0);

  always_comb begin
    lane_dat = '0;
    for (int i = 0; i < NL; i++) begin
      if (lane_oh[i]) lane_dat = lane_dat | hold_data[i*DW +: DW];
    end
  end

  // busy with pend==0 means a keep-less last beat waiting to push its empty marker
  assign push      = busy & ~fifo_full;
  assign push_dat  = {hold_last & final_lane, ~|pend, lane_dat};
  assign ins_ready = rdy_en & (~busy | (push & final_lane));
  assign accept    = ins_valid & ins_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      pend      <= '0;
      hold_last <= 1'b0;
      busy      <= 1'b0;
      rdy_en    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        hold_data <= ins_data;
        pend      <= vmask;
        hold_last <= ins_last;
        busy      <= (|vmask) | ins_last;
      end else if (push) begin
        pend <= pend_rest;
        if (final_lane) busy <= 1'b0;
      end
    end
  end

  cl_sde_sp_fifo #(.W(DW + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (fifo_rdat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign {e_last, e_empty, e_dat} = fifo_rdat;

  always_comb begin
    if (decim == 5'd0)       d_eff = 5'd1;
    else if (decim > 5'd16)  d_eff = 5'd16;
    else                     d_eff = decim;
  end

  assign pop   = ctrl_en & ~fifo_empty & (~ots_valid | ots_ready);
  assign acc_x = e_empty ? acc : (acc ^ e_dat);
  assign cnt_x = e_empty ? cnt : (cnt + 5'd1);
  // >= rather than == so a DECIM lowered mid-group closes on the next lane
  assign close = e_last | (~e_empty & (cnt_x >= d_eff));
  assign mix   = acc_x ^ {NK{key}};

  always_comb begin
    res_nxt = '0;
    for (int j = 0; j < RES_W; j++) res_nxt[j] = mix[j % DW];
  end

  assign ots_keep = ots_valid ? KEEP_MASK : 64'd0;
  assign ots_user = 64'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ots_valid <= 1'b0;
      ots_data  <= '0;
      ots_last  <= 1'b0;
    end else begin
      if (ots_valid & ots_ready) ots_valid <= 1'b0;
      if (pop) begin
        if (close) begin
          acc <= '0;
          cnt <= '0;
          if (cnt_x != 5'd0) begin
            ots_valid <= 1'b1;
            ots_data  <= res_nxt;
            ots_last  <= e_last;
          end
        end else begin
          acc <= acc_x;
          cnt <= cnt_x;
        end
      end
    end
  end

  assign clr = cfg_srm_wr & (cfg_srm_addr == 12'h000) & cfg_srm_wdata[1];

  always_comb begin
    case (cfg_srm_addr)
      12'h000: rd_val = {31'd0, ctrl_en};
      12'h004: rd_val = {27'd0, decim};
      12'h008: rd_val = key;
      12'h00C: rd_val = cnt_beats;
      12'h010: rd_val = cnt_drop;
      12'h014: rd_val = cnt_res;
      12'h018: rd_val = {14'd0, busy, ots_valid, 16'(fifo_level)};
      default: rd_val = 32'hDEADBEEF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en       <= 1'b1;
      decim         <= 5'd2;
      key           <= 32'h55555555;
      cnt_beats     <= '0;
      cnt_drop      <= '0;
      cnt_res       <= '0;
      srm_cfg_ack   <= 1'b0;
      srm_cfg_rdata <= '0;
    end else begin
      srm_cfg_ack   <= cfg_srm_wr | cfg_srm_rd;
      srm_cfg_rdata <= cfg_srm_rd ? rd_val : 32'd0;
      if (cfg_srm_wr) begin
        case (cfg_srm_addr)
          12'h000: ctrl_en <= cfg_srm_wdata[0];
          12'h004: decim   <= cfg_srm_wdata[4:0];
          12'h008: key     <= cfg_srm_wdata;
          default: ;
        endcase
      end
      // clear beats any increment landing on the same edge
      if (clr) begin
        cnt_beats <= '0;
        cnt_drop  <= '0;
        cnt_res   <= '0;
      end else begin
        if (accept)                cnt_beats <= cnt_beats + 32'd1;
        if (accept)                cnt_drop  <= cnt_drop + drop_n;
        if (ots_valid & ots_ready) cnt_res   <= cnt_res + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_cl_sde_stream_proc.sv
`timescale 1ns/1ps
// Randomized bench for cl_sde_stream_proc with a lane-level reference model and output scoreboard.
module tb_cl_sde_stream_proc;
  localparam int DW = 64;
  localparam int FD = 16;
  localparam int RW = 160;
  localparam int NL = 512 / DW;

  logic         clk;
  logic         rst_n;
  logic [11:0]  cfg_srm_addr;
  logic         cfg_srm_wr;
  logic         cfg_srm_rd;
  logic [31:0]  cfg_srm_wdata;
  logic         srm_cfg_ack;
  logic [31:0]  srm_cfg_rdata;
  logic         ins_valid;
  logic         ins_ready;
  logic [511:0] ins_data;
  logic [63:0]  ins_keep;
  logic [63:0]  ins_user;
  logic         ins_last;
  logic         ots_valid;
  logic         ots_ready;
  logic [511:0] ots_data;
  logic [63:0]  ots_keep;
  logic [63:0]  ots_user;
  logic         ots_last;

  cl_sde_stream_proc #(.DW(DW), .FIFO_DEPTH(FD), .RES_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_srm_addr(cfg_srm_addr), .cfg_srm_wr(cfg_srm_wr), .cfg_srm_rd(cfg_srm_rd),
    .cfg_srm_wdata(cfg_srm_wdata), .srm_cfg_ack(srm_cfg_ack), .srm_cfg_rdata(srm_cfg_rdata),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data), .ins_keep(ins_keep),
    .ins_user(ins_user), .ins_last(ins_last),
    .ots_valid(ots_valid), .ots_ready(ots_ready), .ots_data(ots_data), .ots_keep(ots_keep),
    .ots_user(ots_user), .ots_last(ots_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: lanes -> groups of D -> keyed XOR result
  typedef struct {
    logic [511:0] data;
    logic         last;
  } res_t;

  res_t         exp_q[$];
  logic [511:0] obs_dat[$];
  logic         obs_last[$];
  logic [63:0]  macc;
  int           mcnt;
  int           md;
  logic [31:0]  mkey;
  int           m_beats, m_drop, m_res;

  function automatic void m_reset();
    macc = '0; mcnt = 0; md = 2; mkey = 32'h55555555;
    m_beats = 0; m_drop = 0; m_res = 0;
    exp_q.delete();
  endfunction

  function automatic void m_close(input logic lst);
    res_t         r;
    logic [63:0]  mix;
    if (mcnt > 0) begin
      mix    = macc ^ {mkey, mkey};
      r.data = '0;
      for (int j = 0; j < RW; j++) r.data[j] = mix[j % 64];
      r.last = lst;
      exp_q.push_back(r);
      m_res++;
    end
    macc = '0;
    mcnt = 0;
  endfunction

  function automatic void m_beat(input logic [511:0] d, input logic [63:0] k, input logic lst);
    int nv   = 0;
    int seen = 0;
    m_beats++;
    for (int i = 0; i < NL; i++) if (k[i*8 +: 8] == 8'hFF) nv++;
    m_drop += NL - nv;
    if (nv == 0) begin
      if (lst) m_close(1'b1);
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (k[i*8 +: 8] == 8'hFF) begin
          seen++;
          macc ^= d[i*64 +: 64];
          mcnt++;
          if (mcnt >= md || (lst && seen == nv)) m_close(lst && seen == nv);
        end
      end
    end
  endfunction

  // output scoreboard plus hold-stability check
  logic         hold_pend = 1'b0;
  logic [511:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", ots_valid, 1);
        chk("hold_data", ots_data, held);
      end
      hold_pend = ots_valid && !ots_ready;
      held      = ots_data;
      if (ots_valid && ots_ready) begin
        obs_dat.push_back(ots_data);
        obs_last.push_back(ots_last);
        if (exp_q.size() == 0) begin
          chk("unexpected_result", exp_q.size(), 1);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("res_data", ots_data, e.data);
          chk("res_last", ots_last, e.last);
          chk("res_keep", ots_keep, (64'd1 << (RW / 8)) - 64'd1);
          chk("res_user", ots_user, 0);
        end
      end
    end
  end

  // 0: always ready, 1: random, 2: held low
  int rdy_mode = 0;
  initial begin
    ots_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ots_ready = 1'b1;
        1:       ots_ready = ($urandom_range(0, 3) != 0);
        default: ots_ready = 1'b0;
      endcase
    end
  end

  task automatic reg_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_srm_addr = a; cfg_srm_wdata = d; cfg_srm_wr = 1'b1;
    @(posedge clk); #1;
    cfg_srm_wr = 1'b0;
    chk("wr_ack", srm_cfg_ack, 1);
  endtask

  task automatic reg_read(input logic [11:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    cfg_srm_addr = a; cfg_srm_rd = 1'b1;
    @(posedge clk); #1;
    cfg_srm_rd = 1'b0;
    chk("rd_ack", srm_cfg_ack, 1);
    d = srm_cfg_rdata;
  endtask

  task automatic set_decim(input int v);
    reg_write(12'h004, 32'(v));
    md = (v == 0) ? 1 : (v > 16) ? 16 : v;
  endtask

  task automatic set_key(input logic [31:0] k);
    reg_write(12'h008, k);
    mkey = k;
  endtask

  // called just after an active edge; returns just after the accepting edge
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic lst);
    bit got = 0;
    m_beat(d, k, lst);
    ins_valid = 1'b1; ins_data = d; ins_keep = k; ins_last = lst;
    ins_user  = {$urandom, $urandom};
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (ins_ready) got = 1;
      @(posedge clk); #1;
    end
    ins_valid = 1'b0;
    chk("beat_accept", got, 1);
  endtask

  task automatic wait_cycles(input int n);
    for (int c = 0; c < n; c++) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin @(posedge clk); #1; end
    chk("drain", exp_q.size(), 0);
    wait_cycles(4);
  endtask

  task automatic check_counters(input string tag);
    logic [31:0] v;
    reg_read(12'h00C, v); chk({tag, "_beats"}, v, m_beats);
    reg_read(12'h010, v); chk({tag, "_drop"}, v, m_drop);
    reg_read(12'h014, v); chk({tag, "_res"}, v, m_res);
  endtask

  function automatic logic [511:0] rnd_data();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] rnd_keep();
    logic [63:0] k;
    for (int i = 0; i < NL; i++) begin
      int r = $urandom_range(0, 9);
      k[i*8 +: 8] = (r < 7) ? 8'hFF : (r == 7) ? 8'h00 : 8'($urandom);
    end
    return k;
  endfunction

  initial begin
    logic [31:0]  v;
    logic [511:0] d;
    int           decims[6];
    rst_n = 1'b0;
    cfg_srm_addr = '0; cfg_srm_wr = 1'b0; cfg_srm_rd = 1'b0; cfg_srm_wdata = '0;
    ins_valid = 1'b0; ins_data = '0; ins_keep = '0; ins_user = '0; ins_last = 1'b0;
    m_reset();

    // reset state
    #22;
    chk("rst_ins_ready", ins_ready, 0);
    chk("rst_ots_valid", ots_valid, 0);
    chk("rst_ots_data", ots_data, 0);
    chk("rst_ots_keep", ots_keep, 0);
    chk("rst_ack", srm_cfg_ack, 0);
    chk("rst_rdata", srm_cfg_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("pre_edge_ins_ready", ins_ready, 0);
    @(posedge clk); #1;
    chk("post_edge_ins_ready", ins_ready, 1);
    reg_read(12'h000, v); chk("ctrl_reset", v, 32'h1);
    reg_read(12'h004, v); chk("decim_reset", v, 32'h2);
    reg_read(12'h008, v); chk("key_reset", v, 32'h55555555);
    reg_read(12'h3F0, v); chk("unmapped", v, 32'hDEADBEEF);
    reg_read(12'h018, v); chk("status_idle", v, 0);

    // D=2 passthrough, lanes k*0x1111...
    for (int i = 0; i < NL; i++) d[i*64 +: 64] = 64'h1111111111111111 * i;
    obs_dat.delete(); obs_last.delete();
    send_beat(d, {64{1'b1}}, 1'b1);
    wait_drain();
    chk("pt_count", obs_dat.size(), 4);
    if (obs_dat.size() == 4) begin
      chk("pt_res0_low", obs_dat[0][63:0], 64'h4444444444444444);
      chk("pt_res0_last", obs_last[0], 0);
      chk("pt_res3_last", obs_last[3], 1);
    end

    // partial keep, D=4
    reg_write(12'h000, 32'h3);
    m_beats = 0; m_drop = 0; m_res = 0;
    set_decim(4);
    obs_dat.delete(); obs_last.delete();
    for (int i = 0; i < NL; i++) d[i*64 +: 64] = rnd_data()[63:0];
    send_beat(d, 64'h00000000_0000FFF0, 1'b1);
    wait_drain();
    reg_read(12'h010, v); chk("partial_drop", v, 7);
    chk("partial_count", obs_dat.size(), 1);
    check_counters("partial");

    // empty last beat closes a 3-lane group
    reg_write(12'h000, 32'h3);
    m_beats = 0; m_drop = 0; m_res = 0;
    send_beat(rnd_data(), 64'h00000000_00FFFFFF, 1'b0);
    send_beat(rnd_data(), 64'h0, 1'b1);
    wait_drain();
    reg_read(12'h00C, v); chk("emptylast_beats", v, 2);
    reg_read(12'h014, v); chk("emptylast_res", v, 1);

    // first-result latency at D=1
    set_decim(1);
    send_beat(rnd_data(), 64'h00000000_000000FF, 1'b1);
    @(negedge clk); chk("lat_t0", ots_valid, 0);
    @(negedge clk); chk("lat_t1", ots_valid, 0);
    @(negedge clk); chk("lat_t2", ots_valid, 1);
    @(posedge clk); #1;
    wait_drain();

    // en=0 parks lanes in the FIFO
    reg_write(12'h000, 32'h0);
    send_beat(rnd_data(), {64{1'b1}}, 1'b1);
    wait_cycles(20);
    reg_read(12'h018, v); chk("en0_status", v, 32'd8);
    reg_write(12'h000, 32'h1);
    wait_drain();

    // randomized rounds across decimations and keys
    decims = '{0, 1, 3, 31, 16, 5};
    for (int r = 0; r < 6; r++) begin
      set_key($urandom);
      set_decim(decims[r]);
      rdy_mode = 1;
      for (int b = 0; b < 10; b++) send_beat(rnd_data(), rnd_keep(), (b == 9) || ($urandom_range(0, 3) == 0));
      wait_drain();
      rdy_mode = 0;
      reg_read(12'h004, v); chk("decim_rb", v, decims[r]);
    end
    check_counters("rand");

    // output backpressure with continuous input
    set_decim(1);
    rdy_mode = 2;
    wait_cycles(2);
    fork
      begin
        for (int b = 0; b < 4; b++) send_beat(rnd_data(), {64{1'b1}}, b == 3);
      end
      begin
        logic [31:0] s;
        wait_cycles(200);
        reg_read(12'h018, s); chk("bp_level", s[15:0], FD);
        @(negedge clk); chk("bp_ins_ready", ins_ready, 0);
        @(posedge clk); #1;
        rdy_mode = 0;
      end
    join
    wait_drain();

    // clear and read-only writes
    reg_write(12'h000, 32'h3);
    m_beats = 0; m_drop = 0; m_res = 0;
    reg_write(12'h00C, 32'h5);
    check_counters("clr");
    reg_read(12'h000, v); chk("clr_selfclear", v, 32'h1);

    // reset while a beat is half drained
    rdy_mode = 2;
    wait_cycles(2);
    send_beat(rnd_data(), {64{1'b1}}, 1'b1);
    wait_cycles(6);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("midrst_ots_valid", ots_valid, 0);
    chk("midrst_ins_ready", ins_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    reg_read(12'h018, v); chk("midrst_status", v, 0);
    chk("midrst_ots_valid_after", ots_valid, 0);
    rdy_mode = 0;
    obs_dat.delete(); obs_last.delete();
    send_beat(rnd_data(), {64{1'b1}}, 1'b1);
    wait_drain();
    chk("midrst_count", obs_dat.size(), 4);
    check_counters("midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cl_sde_stream_proc.md
# cl_sde_stream_proc

Parametrised successor to the SDE stream-processing slot between the SDE H2C stream (`ins_*`) and C2H stream (`ots_*`). It splits each 512-bit beat into keep-qualified lanes of `DW` bits and buffers them in a `FIFO_DEPTH` FIFO. Every `DECIM` lanes are XOR-reduced into one keyed `RES_W`-bit result, which is sent on one output beat. A real `cfg_srm_*` register file provides control, key and statistics counters.

## Interface
- `DW`, 64: lane width; 512 % `DW` == 0, `DW` % 32 == 0.
- `FIFO_DEPTH`, 16: lane FIFO entries; power of 2, ≥ 4.
- `RES_W`, 160: result width; multiple of 8, ≤ 512.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_srm_addr`  in  12  register byte address.
- `cfg_srm_wr` / `cfg_srm_rd`  in  1  one-cycle access strobes, mutually exclusive.
- `cfg_srm_wdata`  in  32  write data.
- `srm_cfg_ack`  out  1  access done.
- `srm_cfg_rdata`  out  32  read data, valid with ack.
- `ins_valid/ins_ready`  in/out  1  AXI-S input handshake.
- `ins_data`  in  512; `ins_keep`  in  64; `ins_user`  in  64 (ignored); `ins_last`  in  1.
- `ots_valid/ots_ready`  out/in  1  AXI-S output handshake.
- `ots_data`  out  512; `ots_keep`  out  64; `ots_user`  out  64; `ots_last`  out  1.

## Operation
- **Downsizer.** The holding register takes a beat when `ins_valid & ins_ready`.
  - Lanes are scanned low to high, one per cycle, while the FIFO is not full.
  - Lane i is valid iff all `DW/8` keep bits for that lane are set. Other lanes are skipped with zero cycles cost and counted as dropped.
  - `ins_ready` = holding empty, or the final valid lane is being pushed this cycle.
- **FIFO entry** = {last, empty, data[DW-1:0]}.
  - `last` = `ins_last` on the final valid lane of the beat.
  - A beat with no valid lane pushes one entry with empty=1 and last=`ins_last`, or nothing if `ins_last`=0.
- **Reducer.** Pops when CTRL.en=1, the FIFO is not empty, and the output register is empty or accepting this cycle.
  - Non-empty entry: acc ^= data; cnt++.
  - Group closes on cnt==D, or on a last entry.
  - Close with cnt>0 loads the output register and clears acc/cnt. A close with cnt==0 emits nothing.
  - Result bit j = (acc ^ {DW/32{KEY}})[j % DW].
- **Output.**
  - `ots_data[RES_W-1:0]` = result; upper bits are 0.
  - `ots_keep` = low `RES_W/8` bits set.
  - `ots_user` = 0.
  - `ots_last` = closing entry's last flag.
  - Valid is held, with data stable, until `ots_ready`.
- **D (effective decimation)** = DECIM clamped to 1..16; 0 counts as 1.
- **Registers.** Writes to read-only registers are ignored.
  - 0x000 CTRL: [0] en (reset 1), [1] clr (write-1 self-clearing pulse; zeroes all counters).
  - 0x004 DECIM [4:0], reset 2.
  - 0x008 KEY, reset 0x55555555.
  - 0x00C input beats accepted; 0x010 lanes dropped; 0x014 results sent. All are 32-bit wrapping counters, read-only.
  - 0x018 STATUS: [15:0] FIFO level, [16] `ots_valid`, [17] holding busy.
  - Unmapped reads return 0xDEADBEEF.
- **Clear vs. increment.** When clr and an increment coincide, clr wins.

## Timing
- **Reset values.** `ins_ready`=0 while `rst_n`=0, and 1 from the first edge after release. All other outputs are 0 in reset: `ots_*`=0, ack=0, rdata=0.
- **Register access.** Ack and rdata are asserted exactly one cycle after the strobe, for one cycle. A written value takes effect on the cycle of the ack.
- **Latency.** D=1, en=1, no backpressure:
  - Beat accepted at edge t; lane 0 pushed at edge t+1; popped at edge t+2.
  - `ots_valid`=1 after edge t+2.
  - Lanes stream at 1 per cycle; results are sustained at 1 per cycle when D=1.
- **Full FIFO.** The push is stalled and the holding register keeps its lane. A push and a pop in the same cycle are allowed whenever not full.
- **Output backpressure** (`ots_ready`=0 with the output register full) blocks pops. No lane is lost.
- **en=0.** The reducer stops. The FIFO fills, then `ins_ready` drops. acc/cnt are retained.
- **DECIM write mid-group.** The new D applies from the next pop. If cnt ≥ new D, the group closes on the next non-empty pop.
- **Reset asserted mid-operation** clears the FIFO, holding register, acc, output register and registers immediately. No partial beat is emitted after release.

## Test plan
- **D=2, key default, passthrough.** 1 beat, keep all-ones, lanes k = 64'h1111…·k, last=1 → 4 results.
  - Each result's low 64 bits = lane(2i) ^ lane(2i+1) ^ 64'h5555555555555555.
  - `ots_keep`=64'hFFFFF; `ots_last` only on result 4.
- **Partial keep.** keep=64'h00000000_0000FFF0, last=1, D=4 → lane 1 alone forms one result; dropped counter=7; `ots_last`=1.
- **Empty last.** Beat keep=0, last=1 following a beat with 3 valid lanes, D=4 → one result closed by last; counters: beats=2, results=1.
- **Backpressure.** Hold `ots_ready`=0 for 200 cycles with continuous input → STATUS level reaches `FIFO_DEPTH`; `ins_ready`=0; after release, every lane's contribution is present and in order.
- **Registers.** Write DECIM=0 → behaves as D=1. Write DECIM=31 → behaves as D=16. Read 0x3F0 → 0xDEADBEEF. clr → counters read 0.
- **Reset mid-stream.** Assert `rst_n`=0 while a beat is half-drained → `ots_valid`=0 and STATUS=0 after release; the next beat produces results from fresh acc only.
